dlx_mem_responder: RTL and testbench



---
 rtl/dlx_mem_pkg.sv | 37 +++
 rtl/dlx_mem_array.sv | 48 ++++
 rtl/dlx_mem_responder.sv | 147 ++++++++++++++
 tb/tb_dlx_mem_responder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/dlx_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dlx_mem_pkg
//  Description : Shared types and constants for the DLX memory responder:
//                FSM state encoding, MR/MW operation encoding, and the
//                DLX word width.
//  Revision    : 1.0 - initial release
// ============================================================================
package dlx_mem_pkg;

  localparam int DLX_WORD_W = 32;

  // Encoding 2'd3 is never entered; the FSM recovers it to IDLE.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_t;

  // Only MW alone is a write; MR=MW=1 and MR=MW=0 both fall back to a read
  // so an ambiguous request can never corrupt the array.
  function automatic op_t decode_op(input logic mr, input logic mw);
    return (mw && !mr) ? OP_WRITE : OP_READ;
  endfunction

  // Exactly one of MR/MW must be set for a well-formed request.
  function automatic logic op_error(input logic mr, input logic mw);
    return ~(mr ^ mw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/dlx_mem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dlx_mem_array
//  Description : Single-port synchronous RAM, DATA_W x 2^ADDR_W words, with
//                write enable and registered read.
//  Ports       : CLK, RESET (async, clears read register only),
//                i_we / i_re (write / read strobes), i_addr (word index),
//                i_wdata (write data), o_rdata (registered read data)
//  Revision    : 1.0 - initial release
// ============================================================================
module dlx_mem_array #(
    parameter int    DATA_W    = 32,
    parameter int    ADDR_W    = 10,
    parameter string INIT_FILE = ""
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              i_we,
    input  logic              i_re,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [2**ADDR_W];
    logic [DATA_W-1:0] r_rdata;

    // Storage itself is never reset.
    always_ff @(posedge CLK) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
    end

    // Read register only updates on a read strobe, so it holds the last read
    // value through writes and idle cycles.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/dlx_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : dlx_mem_responder
//  Description : Memory-side responder for the DLX REQ/MR/MW/busy protocol.
//                Accepts one word access per request, holds busy for
//                WAIT_STATES cycles, then spends one DONE cycle with busy=0
//                while DOUT carries read data.
//  Ports       : CLK, RESET (async active-high), REQ, MR, MW, ADDR (byte
//                address), DIN (write data), DOUT (registered read data),
//                busy, ERR_o (protocol-error pulse), STATE_o (FSM state)
//  Revision    : 1.0 - initial release
// ============================================================================
module dlx_mem_responder
  import dlx_mem_pkg::*;
#(
  parameter int    DATA_W      = 32,
  parameter int    ADDR_W      = 10,
  parameter int    WAIT_STATES = 2,
  parameter string INIT_FILE   = ""
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  REQ,
  input  logic                  MR,
  input  logic                  MW,
  input  logic [DLX_WORD_W-1:0] ADDR,
  input  logic [DATA_W-1:0]     DIN,
  output logic [DATA_W-1:0]     DOUT,
  output logic                  busy,
  output logic                  ERR_o,
  output logic [1:0]            STATE_o
);

  // Accept edge counts as the first of WAIT_STATES edges, so the WAIT
  // counter starts at WAIT_STATES-2 and DONE is taken when it reaches zero.
  localparam logic [3:0] c_cnt_init = (WAIT_STATES >= 2) ? 4'(WAIT_STATES - 2) : 4'd0;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [3:0]        r_cnt;
  logic [3:0]        w_cnt_nxt;
  logic [ADDR_W-1:0] r_idx;
  logic [DATA_W-1:0] r_din;
  op_t               r_op;

  logic              w_busy;
  logic              w_err;
  logic              w_accept;
  logic              w_enter_done;
  op_t               w_op;
  logic [ADDR_W-1:0] w_idx;
  logic [DATA_W-1:0] w_wdata;
  logic              w_unused_addr;

  assign w_unused_addr = ^{ADDR[DLX_WORD_W-1:ADDR_W+2], ADDR[1:0]};

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_din   <= '0;
      r_op    <= OP_READ;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_idx <= ADDR[ADDR_W+1:2];
        r_din <= DIN;
        r_op  <= decode_op(MR, MW);
      end
    end
  end

  // In IDLE the array sees the live request so a WAIT_STATES=1 access can
  // complete on the accept edge; afterwards it sees only the latched copy.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_busy       = 1'b0;
    w_err        = 1'b0;
    w_accept     = 1'b0;
    w_enter_done = 1'b0;
    w_op         = r_op;
    w_idx        = r_idx;
    w_wdata      = r_din;
    case (r_state)
      IDLE: begin
        w_busy  = REQ;
        w_op    = decode_op(MR, MW);
        w_idx   = ADDR[ADDR_W+1:2];
        w_wdata = DIN;
        if (REQ) begin
          w_accept = 1'b1;
          w_err    = op_error(MR, MW);
          if (WAIT_STATES <= 1) begin
            w_state_nxt  = DONE;
            w_enter_done = 1'b1;
          end else begin
            w_state_nxt = WAIT;
            w_cnt_nxt   = c_cnt_init;
          end
        end
      end
      WAIT: begin
        w_busy = 1'b1;
        if (!REQ) begin
          // Initiator withdrew: drop the access without touching the array.
          w_state_nxt = IDLE;
          w_cnt_nxt   = '0;
        end else if (r_cnt == 4'd0) begin
          w_state_nxt  = DONE;
          w_enter_done = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  dlx_mem_array #(
    .DATA_W    (DATA_W),
    .ADDR_W    (ADDR_W),
    .INIT_FILE (INIT_FILE)
  ) u_array (
    .CLK     (CLK),
    .RESET   (RESET),
    .i_we    (w_enter_done && (w_op == OP_WRITE)),
    .i_re    (w_enter_done && (w_op == OP_READ)),
    .i_addr  (w_idx),
    .i_wdata (w_wdata),
    .o_rdata (DOUT)
  );

  assign busy    = w_busy & ~RESET;
  assign ERR_o   = w_err & ~RESET;
  assign STATE_o = r_state;

endmodule
`default_nettype wire

// File: tb/tb_dlx_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dlx_mem_responder
//  Description : Directed self-checking bench. Instances 0/1/2 run with
//                WAIT_STATES = 2/3/1, each with its own request inputs.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dlx_mem_responder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req   [3];
  logic        mr    [3];
  logic        mw    [3];
  logic [31:0] addr  [3];
  logic [31:0] din   [3];
  logic [31:0] dout_v[3];
  logic        busy_v[3];
  logic        err_v [3];
  logic [1:0]  st_v  [3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dlx_mem_responder #(.WAIT_STATES(2)) u_dut0 (
    .CLK(clk), .RESET(rst), .REQ(req[0]), .MR(mr[0]), .MW(mw[0]), .ADDR(addr[0]),
    .DIN(din[0]), .DOUT(dout_v[0]), .busy(busy_v[0]), .ERR_o(err_v[0]), .STATE_o(st_v[0]));

  dlx_mem_responder #(.WAIT_STATES(3)) u_dut1 (
    .CLK(clk), .RESET(rst), .REQ(req[1]), .MR(mr[1]), .MW(mw[1]), .ADDR(addr[1]),
    .DIN(din[1]), .DOUT(dout_v[1]), .busy(busy_v[1]), .ERR_o(err_v[1]), .STATE_o(st_v[1]));

  dlx_mem_responder #(.WAIT_STATES(1)) u_dut2 (
    .CLK(clk), .RESET(rst), .REQ(req[2]), .MR(mr[2]), .MW(mw[2]), .ADDR(addr[2]),
    .DIN(din[2]), .DOUT(dout_v[2]), .busy(busy_v[2]), .ERR_o(err_v[2]), .STATE_o(st_v[2]));

  // One full access on instance sel; returns busy-cycle count, DOUT in the
  // DONE cycle, and the number of cycles ERR_o was seen high.
  task automatic access(input int sel, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        output int nbusy, output logic [31:0] dout, output int nerr);
    bit done;
    @(negedge clk);
    req[sel] = 1'b1; mr[sel] = r; mw[sel] = w; addr[sel] = a; din[sel] = d;
    nbusy = 0; nerr = 0; done = 0;
    for (int k = 0; k < 40; k++) begin
      #1;
      if (err_v[sel]) nerr++;
      if (!busy_v[sel]) begin
        done = 1;
        break;
      end
      nbusy++;
      @(negedge clk);
    end
    dout = dout_v[sel];
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL access_timeout inst=%0d addr=%h: busy never dropped", sel, a);
    end
    req[sel] = 1'b0; mr[sel] = 1'b0; mw[sel] = 1'b0;
  endtask

  task automatic test_reset();
    req[0] = 1'b1; mr[0] = 1'b1;
    #2;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (busy_v[i] !== 1'b0 || dout_v[i] !== 32'h0 || st_v[i] !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_values inst=%0d: busy=%b dout=%h state=%0d, want 0/0/0",
                 i, busy_v[i], dout_v[i], st_v[i]);
      end
    end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_checks++;
    if (busy_v[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL busy_after_reset: busy=%b, want 1", busy_v[0]);
    end
    req[0] = 1'b0; mr[0] = 1'b0;
  endtask

  task automatic test_write_read();
    int nb; int ne; logic [31:0] d;
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, nb, d, ne);
    n_checks++;
    if (nb !== 2 || ne !== 0) begin
      n_fail++;
      $display("FAIL write_busy: busy_cycles=%0d err=%0d, want 2/0", nb, ne);
    end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, nb, d, ne);
    n_checks++;
    if (nb !== 2 || d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL read_back: busy_cycles=%0d dout=%h, want 2/deadbeef", nb, d);
    end
  endtask

  task automatic test_addr_mask();
    int nb; int ne; logic [31:0] d;
    access(0, 1'b0, 1'b1, 32'h13, 32'h1, nb, d, ne);
    n_checks++;
    if (d !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL dout_hold_on_write: dout=%h, want deadbeef", d);
    end
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, nb, d, ne);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL addr_mask: dout=%h, want 00000001", d);
    end
  endtask

  task automatic test_abort();
    int nb; int ne; logic [31:0] d;
    access(1, 1'b0, 1'b1, 32'h20, 32'hCAFEF00D, nb, d, ne);
    n_checks++;
    if (nb !== 3) begin
      n_fail++;
      $display("FAIL ws3_busy: busy_cycles=%0d, want 3", nb);
    end
    @(negedge clk);
    req[1] = 1'b1; mw[1] = 1'b1; mr[1] = 1'b0; addr[1] = 32'h20; din[1] = 32'h12345678;
    @(negedge clk);
    #1;
    n_checks++;
    if (st_v[1] !== 2'd1) begin
      n_fail++;
      $display("FAIL abort_in_wait: state=%0d, want 1", st_v[1]);
    end
    req[1] = 1'b0; mw[1] = 1'b0;
    @(negedge clk);
    #1;
    n_checks++;
    if (st_v[1] !== 2'd0 || busy_v[1] !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_to_idle: state=%0d busy=%b, want 0/0", st_v[1], busy_v[1]);
    end
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, nb, d, ne);
    n_checks++;
    if (d !== 32'hCAFEF00D || nb !== 3) begin
      n_fail++;
      $display("FAIL abort_no_write: dout=%h busy_cycles=%0d, want cafef00d/3", d, nb);
    end
  endtask

  task automatic test_error();
    int nb; int ne; logic [31:0] d;
    access(0, 1'b0, 1'b1, 32'h30, 32'h77, nb, d, ne);
    access(0, 1'b1, 1'b1, 32'h30, 32'h55, nb, d, ne);
    n_checks++;
    if (ne !== 1 || d !== 32'h77 || nb !== 2) begin
      n_fail++;
      $display("FAIL err_both: err_cycles=%0d dout=%h busy=%0d, want 1/00000077/2", ne, d, nb);
    end
    access(0, 1'b1, 1'b0, 32'h30, 32'h0, nb, d, ne);
    n_checks++;
    if (d !== 32'h77 || ne !== 0) begin
      n_fail++;
      $display("FAIL err_no_write: dout=%h err=%0d, want 00000077/0", d, ne);
    end
    access(0, 1'b0, 1'b0, 32'h10, 32'h0, nb, d, ne);
    n_checks++;
    if (ne !== 1 || d !== 32'h1) begin
      n_fail++;
      $display("FAIL err_none: err_cycles=%0d dout=%h, want 1/00000001", ne, d);
    end
  endtask

  task automatic test_ws1();
    int nb; int ne; logic [31:0] d;
    access(2, 1'b0, 1'b1, 32'h40, 32'h0000A5A5, nb, d, ne);
    n_checks++;
    if (nb !== 1) begin
      n_fail++;
      $display("FAIL ws1_write_busy: busy_cycles=%0d, want 1", nb);
    end
    access(2, 1'b1, 1'b0, 32'h40, 32'h0, nb, d, ne);
    n_checks++;
    if (nb !== 1 || d !== 32'h0000A5A5) begin
      n_fail++;
      $display("FAIL ws1_read: busy_cycles=%0d dout=%h, want 1/0000a5a5", nb, d);
    end
  endtask

  task automatic test_back_to_back();
    logic exp_b;
    @(negedge clk);
    req[2] = 1'b1; mr[2] = 1'b1; mw[2] = 1'b0; addr[2] = 32'h40;
    for (int i = 0; i < 4; i++) begin
      #1;
      exp_b = (i % 2 == 0);
      n_checks++;
      if (busy_v[2] !== exp_b) begin
        n_fail++;
        $display("FAIL back_to_back cycle=%0d: busy=%b, want %b", i, busy_v[2], exp_b);
      end
      if (i < 3) @(negedge clk);
    end
    req[2] = 1'b0; mr[2] = 1'b0;
  endtask

  task automatic test_integration();
    int nb; int ne; logic [31:0] ir; logic [31:0] d; logic [31:0] ea;
    // lw r2, 4(r1) with r1 = 0x40
    access(0, 1'b0, 1'b1, 32'h00, 32'h8C220004, nb, d, ne);
    access(0, 1'b0, 1'b1, 32'h44, 32'h0BADF00D, nb, d, ne);
    access(0, 1'b1, 1'b0, 32'h00, 32'h0, nb, ir, ne);
    n_checks++;
    if (nb !== 2 || ir !== 32'h8C220004) begin
      n_fail++;
      $display("FAIL fetch: busy_cycles=%0d ir=%h, want 2/8c220004", nb, ir);
    end
    ea = 32'h40 + {{16{ir[15]}}, ir[15:0]};
    access(0, 1'b1, 1'b0, ea, 32'h0, nb, d, ne);
    n_checks++;
    if (d !== 32'h0BADF00D || nb !== 2) begin
      n_fail++;
      $display("FAIL load_wb: dout=%h busy_cycles=%0d, want 0badf00d/2", d, nb);
    end
  endtask

  task automatic test_reset_mid_access();
    int nb; int ne; logic [31:0] d;
    @(negedge clk);
    req[0] = 1'b1; mw[0] = 1'b1; mr[0] = 1'b0; addr[0] = 32'h10; din[0] = 32'h99;
    @(negedge clk);
    #1;
    n_checks++;
    if (st_v[0] !== 2'd1) begin
      n_fail++;
      $display("FAIL mid_access_wait: state=%0d, want 1", st_v[0]);
    end
    rst = 1'b1;
    #1;
    n_checks++;
    if (st_v[0] !== 2'd0 || busy_v[0] !== 1'b0 || dout_v[0] !== 32'h0) begin
      n_fail++;
      $display("FAIL mid_access_reset: state=%0d busy=%b dout=%h, want 0/0/0",
               st_v[0], busy_v[0], dout_v[0]);
    end
    req[0] = 1'b0; mw[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, nb, d, ne);
    n_checks++;
    if (d !== 32'h1) begin
      n_fail++;
      $display("FAIL mid_access_no_write: dout=%h, want 00000001", d);
    end
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      req[i] = 1'b0; mr[i] = 1'b0; mw[i] = 1'b0; addr[i] = '0; din[i] = '0;
    end
    test_reset();
    test_write_read();
    test_addr_mask();
    test_abort();
    test_error();
    test_ws1();
    test_back_to_back();
    test_integration();
    test_reset_mid_access();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
